// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and constants for the pipeline stall/flush sequencer
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN         = 2'd0,
    LOAD_BUBBLE = 2'd1,
    MEM_WAIT    = 2'd2,
    REDIRECT    = 2'd3
  } seq_state_t;

  typedef struct packed {
    logic pc_we;
    logic if_de_we;
    logic de_ex_we;
    logic ex_mem_we;
    logic mem_wb_we;
    logic if_de_flush;
    logic de_ex_flush;
    logic mem_wb_flush;
  } stage_ctrl_t;

  localparam int BCNT_W = 3;

  // Canned control words: free-running, reset (everything bubbled) and data-memory wait
  localparam stage_ctrl_t CTRL_RUN   = stage_ctrl_t'(8'b11111_000);
  localparam stage_ctrl_t CTRL_RESET = stage_ctrl_t'(8'b00000_111);
  localparam stage_ctrl_t CTRL_BUSY  = stage_ctrl_t'(8'b00001_001);

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with synchronous active-low reset
module sat_counter #(
  parameter int W = 32
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipeline_sequencer.sv
// rtl/pipeline_sequencer.sv - central stall/flush controller for the 5-stage pipeline
module pipeline_sequencer
  import pipe_ctrl_pkg::*;
#(
  parameter int EXTRA_BUBBLES = 0,
  parameter int CNT_W         = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             lw_stall,
  input  logic             branch_taken,
  input  logic             mem_busy,
  output logic             pc_we,
  output logic             if_de_we,
  output logic             de_ex_we,
  output logic             ex_mem_we,
  output logic             mem_wb_we,
  output logic             if_de_flush,
  output logic             de_ex_flush,
  output logic             mem_wb_flush,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam logic [BCNT_W-1:0] EXTRA_CNT = BCNT_W'(EXTRA_BUBBLES);

  seq_state_t        state, next_state;
  logic [BCNT_W-1:0] bcnt, next_bcnt;
  logic              resume_redirect, next_resume;
  stage_ctrl_t       ctrl;
  logic              stall_inc;
  logic              flush_inc;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state           <= RUN;
      bcnt            <= '0;
      resume_redirect <= 1'b0;
    end else begin
      state           <= next_state;
      bcnt            <= next_bcnt;
      resume_redirect <= next_resume;
    end
  end

  always_comb begin
    ctrl        = CTRL_RUN;
    next_state  = RUN;
    next_bcnt   = bcnt;
    next_resume = resume_redirect;
    flush_inc   = 1'b0;

    if (!RST_N) begin
      ctrl = CTRL_RESET;
    end else if (mem_busy) begin
      // Freeze the front end; MEM/WB takes a bubble each wait cycle so WB never repeats
      ctrl       = CTRL_BUSY;
      next_state = MEM_WAIT;
      if (state == REDIRECT) begin
        next_resume = 1'b1;
      end
    end else if (state == REDIRECT) begin
      // EX holds a bubble here, so any branch_taken is spurious and ignored
      ctrl.if_de_flush = 1'b1;
      if (bcnt <= BCNT_W'(1)) begin
        next_state = RUN;
        next_bcnt  = '0;
      end else begin
        next_state = REDIRECT;
        next_bcnt  = bcnt - BCNT_W'(1);
      end
    end else begin
      next_resume = 1'b0;
      if (branch_taken) begin
        ctrl.if_de_flush = 1'b1;
        ctrl.de_ex_flush = 1'b1;
        flush_inc        = 1'b1;
        if (EXTRA_BUBBLES > 0) begin
          next_state = REDIRECT;
          next_bcnt  = EXTRA_CNT;
        end
      end else if (lw_stall && (state != LOAD_BUBBLE)) begin
        ctrl.pc_we       = 1'b0;
        ctrl.if_de_we    = 1'b0;
        ctrl.de_ex_flush = 1'b1;
        next_state       = LOAD_BUBBLE;
      end
      // A redirect interrupted by a memory wait picks up where it left off
      if ((state == MEM_WAIT) && resume_redirect && !branch_taken) begin
        next_state = REDIRECT;
      end
    end
  end

  assign stall_inc = RST_N && !ctrl.pc_we;

  assign pc_we        = ctrl.pc_we;
  assign if_de_we     = ctrl.if_de_we;
  assign de_ex_we     = ctrl.de_ex_we;
  assign ex_mem_we    = ctrl.ex_mem_we;
  assign mem_wb_we    = ctrl.mem_wb_we;
  assign if_de_flush  = ctrl.if_de_flush;
  assign de_ex_flush  = ctrl.de_ex_flush;
  assign mem_wb_flush = ctrl.mem_wb_flush;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .CLK   (CLK),
    .RST_N (RST_N),
    .inc   (stall_inc),
    .count (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .CLK   (CLK),
    .RST_N (RST_N),
    .inc   (flush_inc),
    .count (flush_events)
  );

endmodule

// File: tb/tb_pipeline_sequencer.sv
// tb/tb_pipeline_sequencer.sv - scoreboard bench for pipeline_sequencer with directed vectors
module tb_pipeline_sequencer;
  import pipe_ctrl_pkg::*;

  localparam int EB = 2;
  localparam int CW = 4;

  // {pc_we, if_de_we, de_ex_we, ex_mem_we, mem_wb_we, if_de_flush, de_ex_flush, mem_wb_flush}
  localparam logic [7:0] E_RUN   = 8'b11111_000;
  localparam logic [7:0] E_RESET = 8'b00000_111;
  localparam logic [7:0] E_BUSY  = 8'b00001_001;
  localparam logic [7:0] E_LOADU = 8'b00111_010;
  localparam logic [7:0] E_BR    = 8'b11111_110;
  localparam logic [7:0] E_RED   = 8'b11111_100;

  typedef struct {
    string      name;
    logic [7:0] ctrl;
    int         stall;
    int         flush;
  } exp_t;

  logic clk, rst_n, lw_stall, branch_taken, mem_busy;
  logic pc_we, if_de_we, de_ex_we, ex_mem_we, mem_wb_we;
  logic if_de_flush, de_ex_flush, mem_wb_flush;
  logic [CW-1:0] stall_cycles, flush_events;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  pipeline_sequencer #(.EXTRA_BUBBLES(EB), .CNT_W(CW)) dut (
    .CLK          (clk),
    .RST_N        (rst_n),
    .lw_stall     (lw_stall),
    .branch_taken (branch_taken),
    .mem_busy     (mem_busy),
    .pc_we        (pc_we),
    .if_de_we     (if_de_we),
    .de_ex_we     (de_ex_we),
    .ex_mem_we    (ex_mem_we),
    .mem_wb_we    (mem_wb_we),
    .if_de_flush  (if_de_flush),
    .de_ex_flush  (de_ex_flush),
    .mem_wb_flush (mem_wb_flush),
    .stall_cycles (stall_cycles),
    .flush_events (flush_events)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input string nm, input logic r, input logic l, input logic b,
                      input logic m, input logic [7:0] c, input int s, input int f);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = r; lw_stall = l; branch_taken = b; mem_busy = m;
    e.name = nm; e.ctrl = c; e.stall = s; e.flush = f;
    sb_q.push_back(e);
  endtask

  // Monitor: outputs are combinational, so every cycle presents a response
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      logic [7:0] got;
      e = sb_q.pop_front();
      got = {pc_we, if_de_we, de_ex_we, ex_mem_we, mem_wb_we, if_de_flush, de_ex_flush, mem_wb_flush};
      checks++;
      if (got !== e.ctrl) begin
        errors++;
        $display("FAIL %s ctrl: got %b expected %b", e.name, got, e.ctrl);
      end
      checks++;
      if (stall_cycles !== CW'(e.stall)) begin
        errors++;
        $display("FAIL %s stall_cycles: got %0d expected %0d", e.name, stall_cycles, e.stall);
      end
      checks++;
      if (flush_events !== CW'(e.flush)) begin
        errors++;
        $display("FAIL %s flush_events: got %0d expected %0d", e.name, flush_events, e.flush);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && dut.state == REDIRECT && branch_taken === 1'b1) begin
      errors++;
      $display("FAIL redirect_branch: got branch_taken=1 in REDIRECT expected 0");
    end
  end

  initial begin
    rst_n = 1'b0; lw_stall = 1'b1; branch_taken = 1'b1; mem_busy = 1'b1;
    // reset held two cycles with all inputs high; first cycle only primes the counters
    step("reset",        0, 1, 1, 1, E_RESET, 0, 0);
    step("release",      1, 0, 0, 0, E_RUN,   0, 0);
    // load-use bubble, lw_stall held over into LOAD_BUBBLE
    step("lu_stall",     1, 1, 0, 0, E_LOADU, 0, 0);
    step("lu_bubble",    1, 1, 0, 0, E_RUN,   1, 0);
    step("lu_after",     1, 0, 0, 0, E_RUN,   1, 0);
    // redirect with two extra bubbles
    step("br_R",         1, 0, 1, 0, E_BR,    1, 0);
    step("br_R1",        1, 0, 0, 0, E_RED,   1, 1);
    step("br_R2",        1, 0, 0, 0, E_RED,   1, 1);
    step("br_R3",        1, 0, 0, 0, E_RUN,   1, 1);
    // branch with lw_stall in the same cycle, then mem_busy in REDIRECT with bcnt=2
    step("br_lw",        1, 1, 1, 0, E_BR,    1, 1);
    step("red_busy1",    1, 0, 0, 1, E_BUSY,  1, 2);
    step("red_busy2",    1, 0, 0, 1, E_BUSY,  2, 2);
    step("red_busy3",    1, 0, 0, 1, E_BUSY,  3, 2);
    step("wait_exit",    1, 0, 0, 0, E_RUN,   4, 2);
    step("resume1",      1, 0, 0, 0, E_RED,   4, 2);
    step("resume2",      1, 0, 0, 0, E_RED,   4, 2);
    step("resume_done",  1, 0, 0, 0, E_RUN,   4, 2);
    // priority: mem_busy over branch and lw_stall; MEM_WAIT exit acts like RUN
    step("busy_prio",    1, 1, 1, 1, E_BUSY,  4, 2);
    step("wait_lu",      1, 1, 0, 0, E_LOADU, 5, 2);
    step("bubble_br",    1, 1, 1, 0, E_BR,    6, 2);
    step("bubble_br_R1", 1, 0, 0, 0, E_RED,   6, 3);
    step("bubble_br_R2", 1, 0, 0, 0, E_RED,   6, 3);
    step("bubble_br_R3", 1, 0, 0, 0, E_RUN,   6, 3);
    // saturation: counters hold their value during the reset cycle, clear after it
    step("sat_reset",    0, 0, 0, 0, E_RESET, 6, 3);
    for (int i = 0; i < 20; i++) begin
      step($sformatf("sat_busy%0d", i), 1, 0, 0, 1, E_BUSY, (i < 15) ? i : 15, 0);
    end
    step("reset_mid",    0, 0, 0, 1, E_RESET, 15, 0);
    step("after_reset",  1, 0, 0, 0, E_RUN,   0, 0);
    step("after_br",     1, 0, 1, 0, E_BR,    0, 0);
    step("after_br_R1",  1, 0, 0, 0, E_RED,   0, 1);
    step("idle",         1, 0, 0, 0, E_RED,   0, 1);

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
    if (sb_q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
